// File: rtl/vga_pkg.sv
// VGA timing constants and shared pixel-stream/sprite types for the 800x600 @ 40 MHz pipeline.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int HOR_TOTAL  = 1056;
  localparam int VER_TOTAL  = 628;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } sprite_pos_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  // Hit tests run in 13 bits so x + width never wraps.
  function automatic logic [12:0] ext13(input logic [11:0] v);
    return {1'b0, v};
  endfunction
endpackage

// File: rtl/vga_if.sv
// VGA timing-plus-colour stream passed between pipeline stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/sprite_hit.sv
// Per-channel sprite hit test and ROM address generation, registered (pipeline stage 1).
module sprite_hit
  import vga_pkg::*;
#(
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       hcount_i,
  input  logic [10:0]       vcount_i,
  input  logic              hblnk_i,
  input  logic              vblnk_i,
  input  sprite_pos_t       pos_i,
  input  logic              en_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] addr_o
);
  logic [12:0]       h, v, x, y, rel_x, rel_y;
  logic              hit_d, hit_q;
  logic [ADDR_W-1:0] addr_d, addr_q;

  always_comb begin
    h      = ext13({1'b0, hcount_i});
    v      = ext13({1'b0, vcount_i});
    x      = ext13(pos_i.x);
    y      = ext13(pos_i.y);
    rel_x  = h - x;
    rel_y  = v - y;
    hit_d  = en_i && !hblnk_i && !vblnk_i &&
             (h >= x) && (h < x + 13'(SPR_W)) &&
             (v >= y) && (v < y + 13'(SPR_H));
    addr_d = hit_d ? ADDR_W'(rel_y * 13'(SPR_W) + rel_x) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      hit_q  <= hit_d;
      addr_q <= addr_d;
    end
  end

  assign hit_o  = hit_q;
  assign addr_o = addr_q;
endmodule

// File: rtl/draw_sprites.sv
// N-channel sprite compositor, 3-cycle latency, lowest channel index on top.
// Optional colour-key transparency is built when SPRITE_TRANSPARENCY_EN is defined.
module draw_sprites
  import vga_pkg::*;
#(
  parameter int          N_SPRITES = 4,
  parameter int          SPR_W     = 64,
  parameter int          SPR_H     = 64,
  parameter int          ADDR_W    = 12,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic                             clk,
  input  logic                             rst_n,
  vga_if.in                                vga_in,
  vga_if.out                               vga_out,
  input  logic [N_SPRITES-1:0][11:0]       xpos_i,
  input  logic [N_SPRITES-1:0][11:0]       ypos_i,
  input  logic [N_SPRITES-1:0]             enable_i,
  output logic [N_SPRITES-1:0][ADDR_W-1:0] rgb_address_o,
  input  logic [N_SPRITES-1:0][11:0]       rgb_pixel_i
);
  sprite_pos_t [N_SPRITES-1:0] pos_q, pos_d;
  logic [N_SPRITES-1:0]        en_q, en_d;
  logic [N_SPRITES-1:0]        hit1, hit2_q, vis;
  logic                        vblnk_prev_q, capture;
  vga_t                        pix_in, s1_q, s2_q, out_q, out_d;

  always_comb begin
    pix_in.hcount = vga_in.hcount;
    pix_in.vcount = vga_in.vcount;
    pix_in.hsync  = vga_in.hsync;
    pix_in.vsync  = vga_in.vsync;
    pix_in.hblnk  = vga_in.hblnk;
    pix_in.vblnk  = vga_in.vblnk;
    pix_in.rgb    = vga_in.rgb;
  end

  // Positions only change at the start of vertical blanking so a frame never tears.
  assign capture = vga_in.vblnk && !vblnk_prev_q;
  assign en_d    = capture ? enable_i : en_q;

  genvar gi;
  for (gi = 0; gi < N_SPRITES; gi++) begin : g_chan
    assign pos_d[gi] = capture ? sprite_pos_t'{x: xpos_i[gi], y: ypos_i[gi]} : pos_q[gi];

    sprite_hit #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .ADDR_W(ADDR_W)
    ) u_hit (
      .clk     (clk),
      .rst_n   (rst_n),
      .hcount_i(vga_in.hcount),
      .vcount_i(vga_in.vcount),
      .hblnk_i (vga_in.hblnk),
      .vblnk_i (vga_in.vblnk),
      .pos_i   (pos_q[gi]),
      .en_i    (en_q[gi]),
      .hit_o   (hit1[gi]),
      .addr_o  (rgb_address_o[gi])
    );

`ifdef SPRITE_TRANSPARENCY_EN
    assign vis[gi] = hit2_q[gi] && (rgb_pixel_i[gi] != KEY_COLOR);
`else
    logic unused_key;
    assign unused_key = ^KEY_COLOR;
    assign vis[gi]    = hit2_q[gi];
`endif
  end

  always_comb begin
    out_d = s2_q;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (vis[i]) out_d.rgb = rgb_pixel_i[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_q <= 1'b0;
      pos_q        <= '0;
      en_q         <= '0;
      hit2_q       <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      out_q        <= '0;
    end else begin
      vblnk_prev_q <= vga_in.vblnk;
      pos_q        <= pos_d;
      en_q         <= en_d;
      hit2_q       <= hit1;
      s1_q         <= pix_in;
      s2_q         <= s1_q;
      out_q        <= out_d;
    end
  end

  assign vga_out.hcount = out_q.hcount;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.rgb    = out_q.rgb;
endmodule

// File: tb/tb_draw_sprites.sv
// Self-checking bench for draw_sprites: table vectors plus scan sequences scored through a latency queue.
module tb_draw_sprites;
  localparam int          N   = 4;
  localparam int          SW  = 64;
  localparam int          SH  = 64;
  localparam int          AW  = 12;
  localparam logic [11:0] KEY = 12'hF0F;
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vga_if vin ();
  vga_if vout ();
  logic [N-1:0][11:0]   xpos, ypos, rgb_pixel;
  logic [N-1:0]         enable;
  logic [N-1:0][AW-1:0] rgb_address;

  draw_sprites #(
    .N_SPRITES(N), .SPR_W(SW), .SPR_H(SH), .ADDR_W(AW), .KEY_COLOR(KEY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_in       (vin),
    .vga_out      (vout),
    .xpos_i       (xpos),
    .ypos_i       (ypos),
    .enable_i     (enable),
    .rgb_address_o(rgb_address),
    .rgb_pixel_i  (rgb_pixel)
  );

  always #5 clk = ~clk;

  // Image ROMs: one registered read per channel.
  logic        rom_const_en = 1'b0;
  logic [11:0] rom_const [N];
  logic [11:0] rom_xor   [N];

  function automatic logic [11:0] rom_fn(input int i, input logic [AW-1:0] a);
    return rom_const_en ? rom_const[i] : (12'(a) ^ rom_xor[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) rgb_pixel[i] <= rom_fn(i, rgb_address[i]);
  end

  typedef struct {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } pix_t;
  typedef struct { int due; string tag; pix_t p; } exp_t;
  typedef struct { int due; logic [AW-1:0] a; } aexp_t;
  typedef struct {
    int          h, v;
    bit          hb;
    logic [11:0] bg, rgb;
    logic [AW-1:0] addr;
  } vec_t;

  exp_t  exp_q[$];
  aexp_t addr_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  bit    rst_req  = 1'b0;
  bit    tab_active = 1'b0;
  logic [11:0]   tab_rgb;
  logic [AW-1:0] tab_addr;
  string cur_tag = "init";

  int m_x[N], m_y[N];
  bit m_en[N];
  bit m_vprev;

  task automatic check_out(input string tag, input pix_t e);
    n_checks++;
    if (vout.hcount === e.h && vout.vcount === e.v && vout.hsync === e.hs &&
        vout.vsync === e.vs && vout.hblnk === e.hb && vout.vblnk === e.vb && vout.rgb === e.rgb)
      n_pass++;
    else
      $display("FAIL %s cyc=%0d got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h",
               tag, cyc, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb,
               e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb);
  endtask

  task automatic check_addr(input string tag, input logic [AW-1:0] want);
    n_checks++;
    if (rgb_address[0] === want) n_pass++;
    else $display("FAIL %s_addr cyc=%0d got %0d want %0d", tag, cyc, rgb_address[0], want);
  endtask

  task automatic step(input int h, input int v, input bit hb, input bit vb, input logic [11:0] bg);
    pix_t zero, e;
    exp_t ex;
    aexp_t ax;
    logic [AW-1:0] a;
    zero = '{h: '0, v: '0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: '0};
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      check_out("reset", zero);
      n_checks++;
      if (rgb_address === '0) n_pass++;
      else $display("FAIL reset_addr cyc=%0d got %h want 0", cyc, rgb_address);
      exp_q.delete();
      addr_q.delete();
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front();
        check_out(ex.tag, ex.p);
      end else begin
        check_out("flush", zero);
      end
      if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
        ax = addr_q.pop_front();
        check_addr(cur_tag, ax.a);
      end
    end

    rst_n      = rst_req;
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = (h >= 840 && h < 968);
    vin.vsync  = (v >= 601 && v < 605);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = bg;

    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_en[i] = 1'b0;
      end
      m_vprev = 1'b0;
    end else begin
      e = '{h: 11'(h), v: 11'(v), hs: vin.hsync, vs: vin.vsync, hb: hb, vb: vb, rgb: bg};
      a = '0;
      for (int i = N - 1; i >= 0; i--) begin
        int ad_i;
        logic [AW-1:0] ad;
        logic [11:0] px;
        if (m_en[i] && !hb && !vb && h >= m_x[i] && h < m_x[i] + SW && v >= m_y[i] && v < m_y[i] + SH) begin
          ad_i = (v - m_y[i]) * SW + (h - m_x[i]);
          ad   = ad_i[AW-1:0];
          px   = rom_fn(i, ad);
          if (i == 0) a = ad;
          if (!(TRANSP && px == KEY)) e.rgb = px;
        end
      end
      if (tab_active) begin
        e.rgb = tab_rgb;
        a     = tab_addr;
      end
      exp_q.push_back('{due: cyc + 3, tag: (tab_active ? "vec" : cur_tag), p: e});
      addr_q.push_back('{due: cyc + 1, a: a});
      if (vb && !m_vprev) begin
        for (int i = 0; i < N; i++) begin
          m_x[i] = int'(xpos[i]); m_y[i] = int'(ypos[i]); m_en[i] = enable[i];
        end
      end
      m_vprev = vb;
    end
  endtask

  task automatic run_row(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) step(h, v, (h >= 800), 1'b0, 12'h5A5 ^ 12'(h));
  endtask

  task automatic vrise();
    step(900, 599, 1'b1, 1'b0, 12'h111);
    step(0, 600, 1'b1, 1'b1, 12'h222);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(900, 0, 1'b1, 1'b0, 12'h000);
  endtask

  task automatic tab_step(input int h, input int v, input logic [11:0] bg,
                          input logic [11:0] rgb, input logic [AW-1:0] addr);
    tab_active = 1'b1;
    tab_rgb    = rgb;
    tab_addr   = addr;
    step(h, v, (h >= 800), 1'b0, bg);
    tab_active = 1'b0;
    $display("txn %s h=%0d v=%0d expect rgb=%h addr0=%0d", cur_tag, h, v, rgb, addr);
  endtask

  task automatic set_spr(input int i, input int x, input int y, input bit en);
    xpos[i]   = 12'(x);
    ypos[i]   = 12'(y);
    enable[i] = en;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{100,  50, 1'b0, 12'h3A0, 12'h000, 12'd0};
    vecs[1]  = '{101,  50, 1'b0, 12'h3A1, 12'h001, 12'd1};
    vecs[2]  = '{163,  50, 1'b0, 12'h3A2, 12'h03F, 12'd63};
    vecs[3]  = '{164,  50, 1'b0, 12'h3A3, 12'h3A3, 12'd0};
    vecs[4]  = '{ 99,  50, 1'b0, 12'h3A4, 12'h3A4, 12'd0};
    vecs[5]  = '{100,  51, 1'b0, 12'h3A5, 12'h040, 12'd64};
    vecs[6]  = '{163,  51, 1'b0, 12'h3A6, 12'h07F, 12'd127};
    vecs[7]  = '{164,  51, 1'b0, 12'h3A7, 12'h3A7, 12'd0};
    vecs[8]  = '{100, 113, 1'b0, 12'h3A8, 12'hFC0, 12'hFC0};
    vecs[9]  = '{163, 113, 1'b0, 12'h3A9, 12'hFFF, 12'hFFF};
    vecs[10] = '{100, 114, 1'b0, 12'h3AA, 12'h3AA, 12'd0};
    vecs[11] = '{100,  49, 1'b0, 12'h3AB, 12'h3AB, 12'd0};
    vecs[12] = '{120,  60, 1'b1, 12'h3AC, 12'h3AC, 12'd0};

    rom_xor   = '{12'h000, 12'h800, 12'h400, 12'hC00};
    rom_const = '{12'hF0F, 12'h0F0, 12'h00F, 12'hFFF};
    xpos = '0; ypos = '0; enable = '0;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

    rst_req = 1'b0;
    idle(4);
    rst_req = 1'b1;

    cur_tag = "single";
    set_spr(0, 100, 50, 1'b1);
    vrise();
    foreach (vecs[k]) begin
      tab_active = 1'b1;
      tab_rgb    = vecs[k].rgb;
      tab_addr   = vecs[k].addr;
      step(vecs[k].h, vecs[k].v, vecs[k].hb, 1'b0, vecs[k].bg);
      tab_active = 1'b0;
      $display("txn vec%0d h=%0d v=%0d hb=%b expect rgb=%h addr0=%0d",
               k, vecs[k].h, vecs[k].v, vecs[k].hb, vecs[k].rgb, vecs[k].addr);
    end

    cur_tag = "overlap";
    set_spr(0, 200, 200, 1'b1);
    set_spr(1, 200, 200, 1'b1);
    vrise();
    run_row(200, 198, 205);
    run_row(263, 260, 265);
    enable[0] = 1'b0;
    run_row(264, 198, 202);
    vrise();
    run_row(200, 198, 205);

    cur_tag = "midframe";
    enable = '0;
    set_spr(0, 250, 90, 1'b1);
    vrise();
    run_row(95, 248, 252);
    xpos[0] = 12'd300;
    run_row(100, 248, 252);
    run_row(100, 298, 302);
    vrise();
    run_row(100, 248, 252);
    run_row(100, 298, 302);

    cur_tag = "clip";
    set_spr(0, 780, 590, 1'b1);
    vrise();
    run_row(599, 776, 798);
    tab_step(799, 599, 12'h5A5 ^ 12'd799, 12'd595, 12'd595);
    run_row(599, 800, 805);
    run_row(590, 778, 781);
    run_row(0, 0, 45);
    run_row(53, 776, 799);

    cur_tag = "transp";
    idle(3);
    rom_const_en = 1'b1;
    set_spr(0, 400, 300, 1'b1);
    set_spr(1, 400, 300, 1'b1);
    vrise();
    tab_step(400, 300, 12'h777, (TRANSP ? 12'h0F0 : 12'hF0F), 12'd0);
    run_row(300, 401, 404);
    run_row(300, 396, 399);
    idle(3);
    rom_const_en = 1'b0;

    cur_tag = "rst_mid";
    enable = '0;
    set_spr(0, 380, 300, 1'b1);
    vrise();
    run_row(300, 395, 400);
    rst_req = 1'b0;
    run_row(300, 401, 405);
    rst_req = 1'b1;
    run_row(300, 406, 420);
    vrise();
    run_row(300, 378, 384);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
